fifo_reader: RTL and testbench

Read-side controller for the team's synchronous FIFO. It issues `fifo_rd_en` into the FIFO and absorbs the one-cycle registered `data_out` latency. It re-presents the words on a valid/ready stream through a 2-entry output buffer, so a consumer holding `m_ready` high drains one word per cycle. It sits between the FIFO read port and any downstream consumer, and also flags protocol errors (underflow).

---
 rtl/shared_pkg.sv | 11 +
 rtl/fifo_rd_skid.sv | 70 +++++++
 rtl/fifo_reader.sv | 62 ++++++
 tb/tb_fifo_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Definitions shared between the synchronous FIFO and its read-side logic.
package shared_pkg;
    localparam int FIFO_WIDTH_DFLT = 16;
    localparam int RD_LATENCY      = 1;

    typedef enum logic [1:0] {OCC_0, OCC_1, OCC_2} occ_e;

    function automatic logic [1:0] occ_num(input occ_e o);
        return o;
    endfunction
endpackage

// File: rtl/fifo_rd_skid.sv
// 2-entry in-order output buffer: push lands in the tail and the head drives the stream.
// Registered head/valid with no bypass, and push into a full buffer is only legal together with a pop.
module fifo_rd_skid
    import shared_pkg::*;
#(
    parameter int W = FIFO_WIDTH_DFLT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         head_vld_o,
    output occ_e         occ_o
);
    occ_e         occ_q, occ_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         vld_q;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push_vld_i, pop_i})
            2'b10: begin
                if (occ_q == OCC_0) begin
                    occ_d  = OCC_1;
                    head_d = push_dat_i;
                end else begin
                    occ_d  = OCC_2;
                    tail_d = push_dat_i;
                end
            end
            2'b01: begin
                occ_d  = (occ_q == OCC_2) ? OCC_1 : OCC_0;
                head_d = (occ_q == OCC_2) ? tail_q : head_q;
            end
            2'b11: begin
                // Occupancy is unchanged; with one entry the new word goes straight to the head.
                if (occ_q == OCC_2) begin
                    head_d = tail_q;
                    tail_d = push_dat_i;
                end else begin
                    head_d = push_dat_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= OCC_0;
            head_q <= '0;
            tail_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            vld_q  <= (occ_d != OCC_0);
        end
    end

    assign head_dat_o = head_q;
    assign head_vld_o = vld_q;
    assign occ_o      = occ_q;
endmodule

// File: rtl/fifo_reader.sv
// FIFO read-port controller: rd_en to m_valid is 2 cycles, sustained 1 word/cycle.
// Reads are issued only while buffered plus in-flight words after this cycle's pop stay below 2.
module fifo_reader
    import shared_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DFLT,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      rd_count,
    output logic                  err_underflow
);
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] rd_count_q;
    logic             err_q;
    logic             pop;
    logic             capture;
    logic [1:0]       level;
    occ_e             occ;

    assign pop        = m_valid && m_ready;
    // Occupancy this read would find on return; pop implies occ >= 1, so no wrap.
    assign level      = occ_num(occ) + {1'b0, inflight_q} - {1'b0, pop};
    assign fifo_rd_en = !rst && en && !fifo_empty && (level < 2'd2);
    assign inflight_d = fifo_rd_en;
    assign capture    = inflight_q && !fifo_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            rd_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (pop) rd_count_q <= rd_count_q + 1'b1;
            if (inflight_q && fifo_underflow) err_q <= 1'b1;
        end
    end

    fifo_rd_skid #(.W(FIFO_WIDTH)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (capture),
        .push_dat_i (fifo_data_out),
        .pop_i      (pop),
        .head_dat_o (m_data),
        .head_vld_o (m_valid),
        .occ_o      (occ)
    );

    assign rd_count      = rd_count_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: FIFO modelled as a queue, delivered stream scored against words handed out.
module tb_fifo_reader;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, en, fifo_empty, fifo_underflow, m_ready;
    logic [W-1:0] fifo_data_out, m_data;
    logic         fifo_rd_en, m_valid, err_underflow;
    logic [15:0]  rd_count;

    always #5 clk = ~clk;

    fifo_reader #(.FIFO_WIDTH(W), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .rd_count       (rd_count),
        .err_underflow  (err_underflow)
    );

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic [15:0]  cnt_m;
    logic         err_m, inject_uf, inflight_good;
    logic         s_rd_en, s_pop, s_rst;
    logic         hold_prev;
    logic [W-1:0] hold_data;
    int           rds, pops;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        x_rd;
        logic        x_vld;
        logic [15:0] x_dat;
        logic [15:0] x_cnt;
    } vec_t;
    vec_t tv[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    task automatic load(input int n, input logic [W-1:0] base);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(base + W'(i));
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // First half of a cycle: compare DUT against the reference at the falling edge.
    task automatic sample();
        int   lvl;
        logic exp_rd;
        @(negedge clk);
        s_rd_en = fifo_rd_en;
        s_rst   = rst;
        s_pop   = m_valid && m_ready && !rst;
        lvl     = exp_q.size() + int'(fifo_underflow) - int'(s_pop);
        exp_rd  = !rst && en && !fifo_empty && (lvl < 2);
        check("rd_en", s_rd_en, exp_rd);
        check("rd_count", rd_count, cnt_m);
        check("err_underflow", err_underflow, err_m);
        check("m_valid", m_valid, (exp_q.size() - int'(inflight_good)) > 0);
        check("occ_bound", (int'(dut.u_skid.occ_q) + int'(dut.inflight_q)) <= 2, 1);
        if (s_pop) begin
            if (exp_q.size() == 0) fail_now("pop_without_word");
            else check("m_data_order", m_data, exp_q[0]);
        end
        if (hold_prev) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, hold_data);
        end
        hold_prev = m_valid && !m_ready && !rst;
        hold_data = m_data;
        if (s_rd_en && fifo_q.size() == 0) fail_now("read_when_empty");
    endtask

    // Second half: advance the reference and the FIFO model just after the rising edge.
    task automatic update();
        logic [W-1:0] w;
        @(posedge clk);
        #1;
        if (s_pop) begin
            w = exp_q.pop_front();
            cnt_m++;
        end
        if (fifo_underflow && !s_rst) err_m = 1'b1;
        inflight_good  = 1'b0;
        if (s_rst) begin
            exp_q.delete();
            cnt_m = '0;
            err_m = 1'b0;
        end
        fifo_underflow = 1'b0;
        if (s_rd_en && fifo_q.size() > 0) begin
            w              = fifo_q.pop_front();
            fifo_data_out  = w;
            fifo_underflow = inject_uf;
            if (!inject_uf) begin
                exp_q.push_back(w);
                inflight_good = 1'b1;
            end
            inject_uf = 1'b0;
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic cycle();
        sample();
        update();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en      = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        if (!fifo_empty) check("rst_rd_en", fifo_rd_en, 0);
        repeat (2) @(posedge clk);
        #1;
        rst            = 1'b0;
        fifo_underflow = 1'b0;
        inject_uf      = 1'b0;
        exp_q.delete();
        cnt_m          = '0;
        err_m          = 1'b0;
        inflight_good  = 1'b0;
        hold_prev      = 1'b0;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_err", err_underflow, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_underflow = 1'b0; fifo_data_out = '0;
        inject_uf = 1'b0; inflight_good = 1'b0; hold_prev = 1'b0;
        hold_data = '0; cnt_m = '0; err_m = 1'b0;

        // Straight-through: 4 words, consumer always ready.
        tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd0};
        tv[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd0};
        tv[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 16'd0};
        tv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 16'd1};
        tv[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0003, 16'd2};
        tv[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0004, 16'd3};
        tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd4};
        do_reset();
        load(4, 16'h0001);
        for (int i = 0; i < 7; i++) begin
            en      = tv[i].en;
            m_ready = tv[i].rdy;
            sample();
            check($sformatf("vec%0d_rd_en", i), s_rd_en, tv[i].x_rd);
            check($sformatf("vec%0d_m_valid", i), m_valid, tv[i].x_vld);
            if (tv[i].x_vld) check($sformatf("vec%0d_m_data", i), m_data, tv[i].x_dat);
            check($sformatf("vec%0d_rd_count", i), rd_count, tv[i].x_cnt);
            update();
        end

        // Backpressure: 5 words, consumer stalled, then released.
        do_reset();
        load(5, 16'h0010);
        en = 1'b1; m_ready = 1'b0; rds = 0;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (s_rd_en) rds++;
            update();
        end
        check("bp_reads", rds, 2);
        check("bp_head", m_data, 16'h0010);
        m_ready = 1'b1; pops = 0;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (s_pop) pops++;
            update();
        end
        check("bp_no_gap", pops, 5);
        check("bp_count", rd_count, 5);

        // Underflow on the first returned word.
        do_reset();
        load(2, 16'h0021);
        en = 1'b1; m_ready = 1'b1; inject_uf = 1'b1; pops = 0;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (s_pop) pops++;
            update();
        end
        check("uf_pops", pops, 1);
        check("uf_err", err_underflow, 1);
        en = 1'b0;
        repeat (5) cycle();
        check("uf_err_sticky", err_underflow, 1);

        // Reset with a full buffer turned into one buffered plus one in flight.
        do_reset();
        load(5, 16'h0030);
        en = 1'b1; m_ready = 1'b0;
        repeat (4) cycle();
        m_ready = 1'b1;
        cycle();
        check("pre_rst_inflight", dut.inflight_q, 1);
        do_reset();
        en = 1'b0; m_ready = 1'b1; pops = 0;
        for (int i = 0; i < 4; i++) begin
            sample();
            if (s_pop) pops++;
            update();
        end
        check("rst_drop_pops", pops, 0);

        // Drop en right after a read was issued.
        do_reset();
        load(3, 16'h0040);
        en = 1'b1; m_ready = 1'b1;
        cycle();
        en = 1'b0; rds = 0; pops = 0;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (s_rd_en) rds++;
            if (s_pop) pops++;
            update();
        end
        check("en_drop_reads", rds, 0);
        check("en_drop_pops", pops, 1);

        // Random traffic against the reference.
        do_reset();
        fifo_q.delete();
        fifo_empty = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) do_reset();
            en        = ($urandom_range(7) != 0);
            m_ready   = ($urandom_range(2) != 0);
            inject_uf = ($urandom_range(63) == 0);
            if ($urandom_range(2) == 0 && fifo_q.size() < 8) fifo_q.push_back(W'($urandom));
            fifo_empty = (fifo_q.size() == 0);
            cycle();
        end

        // Counter wrap at 2^16 pops.
        do_reset();
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 70000 && cnt_m != 16'hFFFF; i++) begin
            if (fifo_q.size() < 4) fifo_q.push_back(W'(i));
            fifo_empty = (fifo_q.size() == 0);
            cycle();
        end
        check("wrap_pre", rd_count, 16'hFFFF);
        cycle();
        check("wrap_zero", rd_count, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
